range_filter_bcd: RTL and testbench

RANGE_FILTER_BCD -- requirements
Module: range_filter_bcd

---
 rtl/range_filter_bcd_pkg.sv | 36 +++
 rtl/range_filter_bcd_bcd_dd.sv | 60 ++++++
 rtl/range_filter_bcd.sv | 248 ++++++++++++++++++++++++
 tb/tb_range_filter_bcd.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/range_filter_bcd_pkg.sv
// Shared types and constants for the range filter / BCD display path.
package range_pkg;

  // Controller states of the measurement pipeline.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIVIDE  = 3'd1,
    AVERAGE = 3'd2,
    CLAMP   = 3'd3,
    CONVERT = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam int CYCLES_PER_MM_DEFAULT = 292;
  localparam int AVG_DEPTH_DEFAULT     = 4;
  localparam int MAX_DISPLAY           = 9999;
  localparam int DIVIDE_CYCLES         = 24;
  localparam int BCD_CYCLES            = 14;

  // BCD image of MAX_DISPLAY, shown on clamp and on timeout.
  localparam logic [15:0] MAX_DISPLAY_BCD = 16'h9999;

  // One double-dabble iteration on a {bcd[15:0], bin[13:0]} shift register:
  // correct every BCD nibble that would overflow on doubling, then shift left.
  function automatic logic [29:0] dd_step(input logic [29:0] sh);
    logic [29:0] adj;
    adj = sh;
    for (int i = 0; i < 4; i++) begin
      if (adj[14 + 4*i +: 4] > 4'd4) begin
        adj[14 + 4*i +: 4] = adj[14 + 4*i +: 4] + 4'd3;
      end
    end
    return {adj[28:0], 1'b0};
  endfunction

endpackage

// File: rtl/range_filter_bcd_bcd_dd.sv
// Sequential double-dabble: converts a 14-bit binary value to four BCD
// digits, one shift per cycle. done_o and digits_o are presented
// combinationally in the last iteration cycle so the caller can register
// the result on the same edge that completes the conversion.
module bcd_dd
  import range_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [13:0]      bin_i,
  output logic [3:0][3:0]  digits_o,
  output logic             done_o
);

  logic [29:0] sh_q, sh_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [29:0] step_s;

  // Next-state for the shift register, iteration counter and busy flag.
  always_comb begin
    step_s   = dd_step(sh_q);
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_o   = 1'b0;
    digits_o = step_s[29:14];
    if (start_i) begin
      sh_d   = {16'd0, bin_i};
      cnt_d  = 4'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sh_d  = step_s;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'(BCD_CYCLES - 1)) begin
        busy_d = 1'b0;
        done_o = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Conversion state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= 30'd0;
      cnt_q  <= 4'd0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/range_filter_bcd.sv
// Ultrasonic range filter: echo width -> millimetres (restoring divide),
// 4-deep moving average, clamp to 9999, BCD conversion for a 4-digit display.
// Every measurement takes a fixed 41 cycles; timeouts answer in 1 cycle.
module range_filter_bcd
  import range_pkg::*;
#(
  parameter int CYCLES_PER_MM = CYCLES_PER_MM_DEFAULT,
  parameter int AVG_DEPTH     = AVG_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        meas_valid,
  input  logic [23:0] meas_width,
  input  logic        meas_timeout,
  output logic        bcd_valid,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit4,
  output logic        over_range,
  output logic [7:0]  overrun_cnt
);

  localparam int          AVG_SHIFT = $clog2(AVG_DEPTH);
  localparam logic [24:0] DIVISOR   = 25'(CYCLES_PER_MM);

  state_e state_q, state_d;

  // Divider: dvd_q holds the dividend and collects quotient bits from the LSB.
  logic [23:0] dvd_q;
  logic [23:0] rem_q;
  logic [4:0]  div_cnt_q;
  logic [24:0] rem_sh_s;
  logic [23:0] rem_n_s;
  logic [23:0] dvd_n_s;
  logic        qbit_s;

  // Averaging window, newest sample in entry 0.
  logic [AVG_DEPTH-1:0][23:0] win_q, win_n_s;
  logic        first_q;
  logic [25:0] sum_old_s;
  logic [25:0] sum_s;
  logic [23:0] mean_s;
  logic [23:0] mean_q;

  // Clamp and conversion.
  logic [13:0] clamp_val_s;
  logic        clamp_ovr_s;
  logic        ovr_q;
  logic        dd_start_s;
  logic        dd_done_s;
  logic [15:0] dd_digits_s;

  // Output staging.
  logic        load_out_s;
  logic [15:0] load_bcd_s;
  logic        load_ovr_s;
  logic [15:0] digits_q;
  logic        over_range_q;
  logic        bcd_valid_q;
  logic [7:0]  overrun_q;

  bcd_dd u_bcd_dd (
    .clk      (clk),
    .rst      (rst),
    .start_i  (dd_start_s),
    .bin_i    (clamp_val_s),
    .digits_o (dd_digits_s),
    .done_o   (dd_done_s)
  );

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh_s = {rem_q, dvd_q[23]};
    if (rem_sh_s >= DIVISOR) begin
      rem_n_s = 24'(rem_sh_s - DIVISOR);
      qbit_s  = 1'b1;
    end else begin
      rem_n_s = rem_sh_s[23:0];
      qbit_s  = 1'b0;
    end
    dvd_n_s = {dvd_q[22:0], qbit_s};
  end

  // Window update and running sum; the very first sample fills the whole window.
  always_comb begin
    sum_old_s = 26'd0;
    for (int i = 0; i < AVG_DEPTH; i++) begin
      sum_old_s = sum_old_s + 26'(win_q[i]);
    end
    win_n_s[0] = dvd_q;
    for (int i = 1; i < AVG_DEPTH; i++) begin
      if (first_q) begin
        win_n_s[i] = dvd_q;
      end else begin
        win_n_s[i] = win_q[i-1];
      end
    end
    if (first_q) begin
      sum_s = 26'(dvd_q) * 26'(AVG_DEPTH);
    end else begin
      sum_s = sum_old_s - 26'(win_q[AVG_DEPTH-1]) + 26'(dvd_q);
    end
    mean_s = 24'(sum_s >> AVG_SHIFT);
  end

  // Saturate the averaged range to what four digits can show.
  always_comb begin
    if (mean_q > 24'(MAX_DISPLAY)) begin
      clamp_val_s = 14'(MAX_DISPLAY);
      clamp_ovr_s = 1'b1;
    end else begin
      clamp_val_s = mean_q[13:0];
      clamp_ovr_s = 1'b0;
    end
  end

  // Controller next state plus output-load decisions.
  always_comb begin
    state_d    = state_q;
    load_out_s = 1'b0;
    load_bcd_s = dd_digits_s;
    load_ovr_s = ovr_q;
    dd_start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (meas_valid) begin
          state_d = DIVIDE;
        end else if (meas_timeout) begin
          state_d    = DONE;
          load_out_s = 1'b1;
          load_bcd_s = MAX_DISPLAY_BCD;
          load_ovr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DIVIDE: begin
        if (div_cnt_q == 5'(DIVIDE_CYCLES - 1)) begin
          state_d = AVERAGE;
        end else begin
          state_d = DIVIDE;
        end
      end
      AVERAGE: begin
        state_d = CLAMP;
      end
      CLAMP: begin
        state_d    = CONVERT;
        dd_start_s = 1'b1;
      end
      CONVERT: begin
        if (dd_done_s) begin
          state_d    = DONE;
          load_out_s = 1'b1;
        end else begin
          state_d = CONVERT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: divider, averaging window and clamp flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q     <= 24'd0;
      rem_q     <= 24'd0;
      div_cnt_q <= 5'd0;
      win_q     <= '0;
      first_q   <= 1'b1;
      mean_q    <= 24'd0;
      ovr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (meas_valid) begin
            dvd_q     <= meas_width;
            rem_q     <= 24'd0;
            div_cnt_q <= 5'd0;
          end
        end
        DIVIDE: begin
          dvd_q     <= dvd_n_s;
          rem_q     <= rem_n_s;
          div_cnt_q <= div_cnt_q + 5'd1;
        end
        AVERAGE: begin
          win_q   <= win_n_s;
          first_q <= 1'b0;
          mean_q  <= mean_s;
        end
        CLAMP: begin
          ovr_q <= clamp_ovr_s;
        end
        default: begin
        end
      endcase
    end
  end

  // Display registers, held between updates; bcd_valid marks the update cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q     <= 16'd0;
      over_range_q <= 1'b0;
      bcd_valid_q  <= 1'b0;
    end else begin
      bcd_valid_q <= load_out_s;
      if (load_out_s) begin
        digits_q     <= load_bcd_s;
        over_range_q <= load_ovr_s;
      end
    end
  end

  // Saturating count of measurements that arrived while a result was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 8'd0;
    end else if (meas_valid && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign bcd_valid   = bcd_valid_q;
  assign digit1      = digits_q[3:0];
  assign digit2      = digits_q[7:4];
  assign digit3      = digits_q[11:8];
  assign digit4      = digits_q[15:12];
  assign over_range  = over_range_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_range_filter_bcd.sv
// Randomized scoreboard bench for range_filter_bcd.
module tb_range_filter_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        meas_valid = 1'b0;
  logic [23:0] meas_width = 24'd0;
  logic        meas_timeout = 1'b0;
  logic        bcd_valid;
  logic [3:0]  digit1, digit2, digit3, digit4;
  logic        over_range;
  logic [7:0]  overrun_cnt;

  range_filter_bcd dut (
    .clk          (clk),
    .rst          (rst),
    .meas_valid   (meas_valid),
    .meas_width   (meas_width),
    .meas_timeout (meas_timeout),
    .bcd_valid    (bcd_valid),
    .digit1       (digit1),
    .digit2       (digit2),
    .digit3       (digit3),
    .digit4       (digit4),
    .over_range   (over_range),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] dig;
    logic        ovr;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned win[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_dig = 16'd0;
  logic        m_ovr = 1'b0;
  int unsigned m_ovf = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int unsigned v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference: millimetres, 4-sample mean, clamp, decimal digits.
  function automatic void model_measure(input logic [23:0] w);
    int unsigned      q;
    longint unsigned  sum;
    int unsigned      mean;
    q = 32'(w) / 32'd292;
    if (win.size() == 0) begin
      for (int i = 0; i < 4; i++) win.push_back(q);
    end else begin
      win.push_front(q);
      void'(win.pop_back());
    end
    sum = 0;
    foreach (win[i]) sum += win[i];
    mean = 32'(sum / 4);
    if (mean > 9999) begin
      m_dig = 16'h9999;
      m_ovr = 1'b1;
    end else begin
      m_dig = to_bcd(mean);
      m_ovr = 1'b0;
    end
  endfunction

  // Monitor: every bcd_valid pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bcd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bcd_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("digits", 32'({digit4, digit3, digit2, digit1}), 32'(mon_e.dig));
        check("over_range", 32'(over_range), 32'(mon_e.ovr));
        check("latency_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    meas_valid = 1'b0;
    meas_timeout = 1'b0;
    exp_q.delete();
    win.delete();
    m_dig = 16'd0;
    m_ovr = 1'b0;
    m_ovf = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_digits", 32'({digit4, digit3, digit2, digit1}), 32'd0);
    check("reset_over_range", 32'(over_range), 32'd0);
    check("reset_bcd_valid", 32'(bcd_valid), 32'd0);
    check("reset_overrun", 32'(overrun_cnt), 32'd0);
  endtask

  // Issue one measurement; extra meas_valid pulses at offsets p1, p2 and lo..hi
  // land while the block is busy and must only be counted.
  task automatic send_meas(input logic [23:0] w, input logic to, input int p1, input int p2,
                           input int lo, input int hi);
    int unsigned n;
    logic        v;
    @(negedge clk);
    meas_valid = 1'b1;
    meas_width = w;
    meas_timeout = to;
    n = cyc;
    model_measure(w);
    exp_q.push_back('{m_dig, m_ovr, n + 41});
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      v = (k <= 40) && ((k == p1) || (k == p2) || ((k >= lo) && (k <= hi)));
      meas_valid = v;
      meas_width = 24'($urandom);
      meas_timeout = (k <= 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (v && (m_ovf < 255)) m_ovf++;
    end
    meas_valid = 1'b0;
    meas_timeout = 1'b0;
  endtask

  task automatic send_timeout();
    @(negedge clk);
    meas_timeout = 1'b1;
    meas_valid = 1'b0;
    m_dig = 16'h9999;
    m_ovr = 1'b1;
    exp_q.push_back('{m_dig, m_ovr, cyc + 1});
    @(negedge clk);
    meas_timeout = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      check("result_wait_expired", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic check_hold(input string name);
    check({name, "_held_digits"}, 32'({digit4, digit3, digit2, digit1}), 32'(m_dig));
    check({name, "_held_over_range"}, 32'(over_range), 32'(m_ovr));
    check({name, "_overrun_cnt"}, 32'(overrun_cnt), m_ovf);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r;
    logic [23:0] w;
    logic        to;
    int          p1;

    do_reset();
    send_meas(24'd360328, 1'b0, 0, 0, 0, -1); wait_done(); check_hold("d1234");
    check("d1234_literal", 32'({digit4, digit3, digit2, digit1}), 32'h1234);
    send_meas(24'd292000, 1'b0, 0, 0, 0, -1); wait_done(); check_hold("d1175");
    check("d1175_literal", 32'({digit4, digit3, digit2, digit1}), 32'h1175);

    do_reset();
    send_meas(24'hFFFFFF, 1'b0, 0, 0, 0, -1); wait_done(); check_hold("full_scale");
    send_timeout(); wait_done(); check_hold("timeout");
    send_meas(24'd29200, 1'b0, 0, 0, 0, -1); wait_done(); check_hold("after_timeout");

    do_reset();
    send_meas(24'd360328, 1'b0, 5, 30, 0, -1); wait_done(); check_hold("overrun2");
    check("overrun_two", 32'(overrun_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      send_meas(24'($urandom_range(0, 3000000)), 1'b0, 0, 0, 1, 40); wait_done();
    end
    check_hold("overrun_sat");
    check("overrun_255", 32'(overrun_cnt), 32'd255);

    do_reset();
    send_meas(24'd2919999, 1'b0, 0, 0, 0, -1); wait_done(); check_hold("edge_9999");
    do_reset();
    send_meas(24'd2920000, 1'b0, 0, 0, 0, -1); wait_done(); check_hold("edge_10000");
    send_meas(24'd291, 1'b1, 0, 0, 0, -1); wait_done(); check_hold("valid_and_timeout");

    // Abort a measurement during conversion; reset also masks live inputs.
    do_reset();
    send_meas(24'd360328, 1'b0, 0, 0, 0, -1); wait_done();
    @(negedge clk);
    meas_valid = 1'b1;
    meas_width = 24'd5000000;
    @(negedge clk);
    meas_valid = 1'b0;
    repeat (28) @(negedge clk);
    rst = 1'b1;
    meas_valid = 1'b1;
    meas_timeout = 1'b1;
    win.delete();
    m_dig = 16'd0;
    m_ovr = 1'b0;
    m_ovf = 0;
    @(negedge clk);
    rst = 1'b0;
    meas_valid = 1'b0;
    meas_timeout = 1'b0;
    repeat (60) @(negedge clk);
    check_hold("abort");
    send_meas(24'd292000, 1'b0, 0, 0, 0, -1); wait_done(); check_hold("after_abort");

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        send_timeout();
      end else begin
        case ($urandom_range(0, 2))
          0: w = 24'($urandom_range(0, 65535));
          1: w = 24'($urandom_range(2500000, 3300000));
          default: w = 24'($urandom);
        endcase
        to = (r == 2);
        p1 = (r == 3) ? $urandom_range(1, 40) : 0;
        send_meas(w, to, p1, 0, 0, -1);
      end
      wait_done();
      check_hold("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
